// File: rtl/uartm_cmd_bridge.sv
// rtl/uartm_cmd_bridge.sv - UART command frames to 32-bit register-bus requests
//
// Receives 'W' addr[4] data[4] or 'R' addr[4] frames (LSB first) on rxd,
// issues one request on the bus_* port and returns the reply bytes on rsp_*.
// Ports:
//   CLK, nRESET          clock, synchronous active-low reset
//   baud_div             clocks per UART bit minus 1 (values below 3 act as 3)
//   rxd                  asynchronous serial input, idle high
//   bus_valid/bus_write/bus_addr/bus_wdata  request, held until bus_ready
//   bus_ready/bus_rdata  slave acceptance and read data
//   rsp_byte/rsp_valid/rsp_ready            response byte stream
//   frame_err            one-cycle pulse on any rejected byte or timeout
// Optional: define UARTM_TIMEOUT_EN for the inter-byte timeout in ADDR/DATA.
module uartm_cmd_bridge #(
  parameter int BAUD_DIV_W   = 16,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic                  CLK,
  input  logic                  nRESET,
  input  logic [BAUD_DIV_W-1:0] baud_div,
  input  logic                  rxd,
  output logic                  bus_valid,
  output logic                  bus_write,
  output logic [31:0]           bus_addr,
  output logic [31:0]           bus_wdata,
  input  logic                  bus_ready,
  input  logic [31:0]           bus_rdata,
  output logic [7:0]            rsp_byte,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  frame_err
);

  typedef enum logic [2:0] {S_CMD, S_ADDR, S_DATA, S_BUS, S_RSP} state_t;

  state_t state, state_next;

  logic                  sync1, sync2, rx_prev;
  logic                  rx_busy;
  logic [3:0]            rx_bit;      // 0 = start, 1..8 = data, 9 = stop
  logic [BAUD_DIV_W-1:0] rx_cnt, rx_div, div_clamp, half_m1;
  logic [7:0]            rx_shift;
  logic                  rx_sample, rx_done, rx_bad;
  logic                  err, tmo_fire;
  logic [1:0]            idx;
  logic [23:0]           rsp_hi;
  logic [1:0]            rsp_left;

  assign div_clamp = (baud_div < BAUD_DIV_W'(3)) ? BAUD_DIV_W'(3) : baud_div;
  // (d+1)/2 - 1 == (d-1)/2 for d >= 3; avoids a wider intermediate
  assign half_m1   = (div_clamp - BAUD_DIV_W'(1)) >> 1;

  assign rx_sample = rx_busy && (rx_cnt == '0);
  assign rx_done   = rx_sample && (rx_bit == 4'd9) && sync2;
  assign rx_bad    = rx_sample && (rx_bit == 4'd9) && !sync2;

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_busy  <= 1'b0;
      rx_bit   <= '0;
      rx_cnt   <= '0;
      rx_div   <= '0;
      rx_shift <= '0;
    end else begin
      sync1   <= rxd;
      sync2   <= sync1;
      rx_prev <= sync2;
      if (!rx_busy) begin
        if (rx_prev && !sync2) begin
          rx_busy <= 1'b1;
          rx_bit  <= '0;
          rx_div  <= div_clamp;
          rx_cnt  <= half_m1;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - BAUD_DIV_W'(1);
      end else begin
        rx_cnt <= rx_div;
        rx_bit <= rx_bit + 4'd1;
        if (rx_bit == 4'd0) begin
          if (sync2) rx_busy <= 1'b0;   // glitch, not a real start bit
        end else if (rx_bit == 4'd9) begin
          rx_busy <= 1'b0;
        end else begin
          rx_shift <= {sync2, rx_shift[7:1]};
        end
      end
    end
  end

`ifdef UARTM_TIMEOUT_EN
  logic [BAUD_DIV_W-1:0] tmo_clk;
  logic [31:0]           tmo_bits;
  logic                  tmo_active, tmo_tick;

  assign tmo_active = (state == S_ADDR) || (state == S_DATA);
  assign tmo_tick   = (tmo_clk >= div_clamp);
  assign tmo_fire   = tmo_active && tmo_tick && (tmo_bits == 32'(TIMEOUT_BITS));

  always_ff @(posedge CLK) begin
    if (!nRESET || !tmo_active || rx_done) begin
      tmo_clk  <= '0;
      tmo_bits <= '0;
    end else if (tmo_tick) begin
      tmo_clk  <= '0;
      tmo_bits <= tmo_bits + 32'd1;
    end else begin
      tmo_clk <= tmo_clk + BAUD_DIV_W'(1);
    end
  end
`else
  logic [31:0] unused_timeout_bits;
  assign unused_timeout_bits = 32'(TIMEOUT_BITS);
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    state_next = state;
    err        = 1'b0;
    if (rx_bad) begin
      // a broken frame aborts collection, but never an issued request
      err = 1'b1;
      if (state == S_CMD || state == S_ADDR || state == S_DATA) state_next = S_CMD;
    end else if (rx_done) begin
      case (state)
        S_CMD:   if (rx_shift == 8'h57 || rx_shift == 8'h52) state_next = S_ADDR;
                 else err = 1'b1;
        S_ADDR:  if (idx == 2'd3) state_next = bus_write ? S_DATA : S_BUS;
        S_DATA:  if (idx == 2'd3) state_next = S_BUS;
        default: err = 1'b1;
      endcase
    end else if (tmo_fire) begin
      err        = 1'b1;
      state_next = S_CMD;
    end
    if (state == S_BUS && bus_ready) state_next = S_RSP;
    if (state == S_RSP && rsp_ready && rsp_left == 2'd0) state_next = S_CMD;
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state     <= S_CMD;
      bus_write <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      idx       <= '0;
      rsp_byte  <= '0;
      rsp_hi    <= '0;
      rsp_left  <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      frame_err <= err;
      if (rx_done) begin
        case (state)
          S_CMD: begin
            bus_write <= (rx_shift == 8'h57);
            idx       <= '0;
          end
          S_ADDR: begin
            bus_addr <= {rx_shift, bus_addr[31:8]};
            idx      <= idx + 2'd1;
          end
          S_DATA: begin
            bus_wdata <= {rx_shift, bus_wdata[31:8]};
            idx       <= idx + 2'd1;
          end
          default: ;
        endcase
      end
      if (state == S_BUS && bus_ready) begin
        rsp_byte <= bus_write ? 8'h06 : bus_rdata[7:0];
        rsp_hi   <= bus_rdata[31:8];
        rsp_left <= bus_write ? 2'd0 : 2'd3;
      end
      if (state == S_RSP && rsp_ready) begin
        rsp_byte <= rsp_hi[7:0];
        rsp_hi   <= {8'h00, rsp_hi[23:8]};
        rsp_left <= rsp_left - 2'd1;
      end
    end
  end

  assign bus_valid = (state == S_BUS);
  assign rsp_valid = (state == S_RSP);

endmodule

// File: tb/tb_uartm_cmd_bridge.sv
// tb/tb_uartm_cmd_bridge.sv - directed self-checking bench for uartm_cmd_bridge
module tb_uartm_cmd_bridge;

  logic        CLK;
  logic        nRESET;
  logic [15:0] baud_div;
  logic        rxd;
  logic        bus_valid, bus_write, bus_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [7:0]  rsp_byte;
  logic        rsp_valid, rsp_ready, frame_err;

  int vectors = 0;
  int miscompares = 0;
  int err_cnt = 0;
  int bv_cycles = 0;
  logic [7:0] tx[$];

  uartm_cmd_bridge dut (
    .CLK(CLK), .nRESET(nRESET), .baud_div(baud_div), .rxd(rxd),
    .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .rsp_byte(rsp_byte), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .frame_err(frame_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(negedge CLK) begin
    if (frame_err) err_cnt++;
    if (bus_valid) bv_cycles++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // baud_div = 9 -> 10 clocks per bit
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0; repeat (10) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i]; repeat (10) tick();
    end
    rxd = stop; repeat (10) tick();
    rxd = 1'b1; repeat (20) tick();
  endtask

  task automatic send_tx;
    foreach (tx[i]) send_byte(tx[i], 1'b1);
  endtask

  task automatic bus_handshake(input int lat, input logic [31:0] rdata, output logic got,
                               output logic w, output logic [31:0] a, output logic [31:0] d);
    got = 1'b0; w = 1'b0; a = '0; d = '0;
    for (int i = 0; i < 500 && !got; i++) begin
      if (bus_valid) got = 1'b1; else tick();
    end
    if (got) begin
      repeat (lat) tick();
      w = bus_write; a = bus_addr; d = bus_wdata;
      bus_rdata = rdata; bus_ready = 1'b1;
      tick();
      bus_ready = 1'b0;
    end
  endtask

  task automatic rsp_take(output logic got, output logic [7:0] b);
    got = 1'b0; b = '0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (rsp_valid) got = 1'b1; else tick();
    end
    if (got) begin
      b = rsp_byte; rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    nRESET = 1'b0;
    repeat (3) tick();
    vectors++; if (bus_valid !== 1'b0) begin miscompares++; $display("FAIL rst_bus_valid got %0h exp 0", bus_valid); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid got %0h exp 0", rsp_valid); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL rst_frame_err got %0h exp 0", frame_err); end
    vectors++; if ({bus_write, bus_addr, bus_wdata, rsp_byte} !== 73'h0) begin miscompares++; $display("FAIL rst_regs got %0h/%0h/%0h/%0h exp 0", bus_write, bus_addr, bus_wdata, rsp_byte); end
    nRESET = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_write;
    logic got; logic [7:0] b; int e0;
    e0 = err_cnt;
    tx = '{8'h57, 8'h18, 8'h00, 8'h00, 8'h40, 8'h18, 8'h00, 8'h00, 8'h00};
    send_tx();
    vectors++; if (bus_valid !== 1'b1) begin miscompares++; $display("FAIL wr_bus_valid got %0h exp 1", bus_valid); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({bus_valid, bus_write, bus_addr, bus_wdata} !== {1'b1, 1'b1, 32'h40000018, 32'h00000018}) begin
        miscompares++; $display("FAIL wr_hold%0d got v%0h w%0h a%08h d%08h exp v1 w1 a40000018 d00000018", i, bus_valid, bus_write, bus_addr, bus_wdata);
      end
      tick();
    end
    bus_ready = 1'b1; tick(); bus_ready = 1'b0;
    vectors++; if (bus_valid !== 1'b0) begin miscompares++; $display("FAIL wr_bus_drop got %0h exp 0", bus_valid); end
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL wr_rsp_valid got %0h exp 1", rsp_valid); end
    rsp_take(got, b);
    vectors++; if (got !== 1'b1 || b !== 8'h06) begin miscompares++; $display("FAIL wr_rsp got %0h/%02h exp 1/06", got, b); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL wr_rsp_end got %0h exp 0", rsp_valid); end
    vectors++; if (err_cnt - e0 != 0) begin miscompares++; $display("FAIL wr_no_err got %0d exp 0", err_cnt - e0); end
  endtask

  task automatic test_read_stall;
    logic got, w; logic [31:0] a, d; logic [7:0] b;
    tx = '{8'h52, 8'h00, 8'h10, 8'h00, 8'h40};
    send_tx();
    bus_handshake(0, 32'hDEADBEEF, got, w, a, d);
    vectors++; if ({got, w, a} !== {1'b1, 1'b0, 32'h40001000}) begin miscompares++; $display("FAIL rd_req got g%0h w%0h a%08h exp g1 w0 a40001000", got, w, a); end
    rsp_take(got, b);
    vectors++; if (b !== 8'hEF) begin miscompares++; $display("FAIL rd_b0 got %02h exp EF", b); end
    rsp_take(got, b);
    vectors++; if (b !== 8'hBE) begin miscompares++; $display("FAIL rd_b1 got %02h exp BE", b); end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({rsp_valid, rsp_byte} !== {1'b1, 8'hAD}) begin miscompares++; $display("FAIL rd_stall%0d got v%0h %02h exp v1 AD", i, rsp_valid, rsp_byte); end
      tick();
    end
    rsp_take(got, b);
    vectors++; if (b !== 8'hAD) begin miscompares++; $display("FAIL rd_b2 got %02h exp AD", b); end
    rsp_take(got, b);
    vectors++; if (b !== 8'hDE) begin miscompares++; $display("FAIL rd_b3 got %02h exp DE", b); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rd_end got %0h exp 0", rsp_valid); end
  endtask

  task automatic test_bad_cmd;
    logic got, w; logic [31:0] a, d; logic [7:0] b; int e0, v0;
    e0 = err_cnt; v0 = bv_cycles;
    send_byte(8'h41, 1'b1);
    vectors++; if (err_cnt - e0 != 1) begin miscompares++; $display("FAIL badcmd_err got %0d exp 1", err_cnt - e0); end
    vectors++; if (bv_cycles - v0 != 0) begin miscompares++; $display("FAIL badcmd_nobus got %0d exp 0", bv_cycles - v0); end
    tx = '{8'h57, 8'h04, 8'h00, 8'h00, 8'h40, 8'h78, 8'h56, 8'h34, 8'h12};
    send_tx();
    bus_handshake(1, 32'h0, got, w, a, d);
    vectors++; if ({got, w, a, d} !== {1'b1, 1'b1, 32'h40000004, 32'h12345678}) begin miscompares++; $display("FAIL badcmd_wr got g%0h w%0h a%08h d%08h exp g1 w1 a40000004 d12345678", got, w, a, d); end
    rsp_take(got, b);
    vectors++; if (b !== 8'h06) begin miscompares++; $display("FAIL badcmd_rsp got %02h exp 06", b); end
  endtask

  task automatic test_stop_err;
    logic got, w; logic [31:0] a, d; logic [7:0] b; int e0, v0;
    e0 = err_cnt; v0 = bv_cycles;
    send_byte(8'h57, 1'b1);
    send_byte(8'h18, 1'b1);
    send_byte(8'h00, 1'b0);
    vectors++; if (err_cnt - e0 != 1) begin miscompares++; $display("FAIL stop_err got %0d exp 1", err_cnt - e0); end
    vectors++; if (bv_cycles - v0 != 0) begin miscompares++; $display("FAIL stop_nobus got %0d exp 0", bv_cycles - v0); end
    tx = '{8'h57, 8'h20, 8'h00, 8'h00, 8'h40, 8'hAA, 8'h00, 8'h00, 8'h00};
    send_tx();
    bus_handshake(0, 32'h0, got, w, a, d);
    vectors++; if ({got, a, d} !== {1'b1, 32'h40000020, 32'h000000AA}) begin miscompares++; $display("FAIL stop_recover got g%0h a%08h d%08h exp g1 a40000020 d000000AA", got, a, d); end
    rsp_take(got, b);
    vectors++; if (err_cnt - e0 != 1) begin miscompares++; $display("FAIL stop_err_total got %0d exp 1", err_cnt - e0); end
  endtask

  task automatic test_timeout;
    logic got, w; logic [31:0] a, d; logic [7:0] b; int e0, v0;
    e0 = err_cnt; v0 = bv_cycles;
    tx = '{8'h57, 8'h18, 8'h00};
    send_tx();
    repeat (400) tick();
`ifdef UARTM_TIMEOUT_EN
    vectors++; if (err_cnt - e0 != 1) begin miscompares++; $display("FAIL tmo_err got %0d exp 1", err_cnt - e0); end
    vectors++; if (bv_cycles - v0 != 0) begin miscompares++; $display("FAIL tmo_nobus got %0d exp 0", bv_cycles - v0); end
    tx = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h40};
    send_tx();
    bus_handshake(0, 32'h11223344, got, w, a, d);
    vectors++; if ({got, w, a} !== {1'b1, 1'b0, 32'h40000008}) begin miscompares++; $display("FAIL tmo_recover got g%0h w%0h a%08h exp g1 w0 a40000008", got, w, a); end
    for (int i = 0; i < 4; i++) rsp_take(got, b);
    vectors++; if (b !== 8'h11) begin miscompares++; $display("FAIL tmo_rsp_last got %02h exp 11", b); end
`else
    vectors++; if (err_cnt - e0 != 0) begin miscompares++; $display("FAIL notmo_err got %0d exp 0", err_cnt - e0); end
    tx = '{8'h00, 8'h40, 8'h18, 8'h00, 8'h00, 8'h00};
    send_tx();
    bus_handshake(0, 32'h0, got, w, a, d);
    vectors++; if ({got, w, a, d} !== {1'b1, 1'b1, 32'h40000018, 32'h00000018}) begin miscompares++; $display("FAIL notmo_req got g%0h w%0h a%08h d%08h exp g1 w1 a40000018 d00000018", got, w, a, d); end
    rsp_take(got, b);
    vectors++; if (b !== 8'h06) begin miscompares++; $display("FAIL notmo_rsp got %02h exp 06", b); end
`endif
  endtask

  task automatic test_reset_in_bus;
    logic got, w; logic [31:0] a, d; logic [7:0] b; int rv;
    tx = '{8'h57, 8'h30, 8'h00, 8'h00, 8'h40, 8'h01, 8'h00, 8'h00, 8'h00};
    send_tx();
    vectors++; if (bus_valid !== 1'b1) begin miscompares++; $display("FAIL rstbus_pre got %0h exp 1", bus_valid); end
    nRESET = 1'b0; tick(); nRESET = 1'b1;
    vectors++; if (bus_valid !== 1'b0) begin miscompares++; $display("FAIL rstbus_drop got %0h exp 0", bus_valid); end
    rv = 0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid || bus_valid) rv++;
      tick();
    end
    vectors++; if (rv != 0) begin miscompares++; $display("FAIL rstbus_quiet got %0d exp 0", rv); end
    tx = '{8'h52, 8'h0C, 8'h00, 8'h00, 8'h40};
    send_tx();
    bus_handshake(2, 32'h01020304, got, w, a, d);
    vectors++; if ({got, w, a} !== {1'b1, 1'b0, 32'h4000000C}) begin miscompares++; $display("FAIL rstbus_recover got g%0h w%0h a%08h exp g1 w0 a4000000C", got, w, a); end
    rsp_take(got, b);
    vectors++; if (b !== 8'h04) begin miscompares++; $display("FAIL rstbus_rsp0 got %02h exp 04", b); end
    for (int i = 0; i < 3; i++) rsp_take(got, b);
  endtask

  initial begin
    nRESET = 1'b0; baud_div = 16'd9; rxd = 1'b1;
    bus_ready = 1'b0; bus_rdata = '0; rsp_ready = 1'b0;
    tick();
    test_reset();
    test_write();
    test_read_stall();
    test_bad_cmd();
    test_stop_err();
    test_timeout();
    test_reset_in_bus();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
